// File: rtl/mips_debug_frame_serializer_if.sv
// mips_debug_frame_serializer_if: request/source/frame bundle between the debug taps, the
// debug interface and the MIPS frame serializer.
interface mips_debug_frame_serializer_if #(
  parameter int NB_FRAME = 32,
  parameter int NB_LATCH = 96,
  parameter int N_LATCH  = 8
);
  logic [5:0]                  i_request_select;
  logic [4:0]                  o_reg_addr;
  logic [NB_FRAME-1:0]         i_reg_data;
  logic [NB_FRAME-1:0]         i_pc;
  logic [NB_FRAME-1:0]         i_mem_data;
  logic [NB_FRAME-1:0]         i_instr_data;
  logic [N_LATCH*NB_LATCH-1:0] i_latch_data;
  logic [NB_FRAME-1:0]         o_frame;
  logic                        o_eod;
  logic                        o_busy;
  modport slave (
    input  i_request_select, i_reg_data, i_pc, i_mem_data, i_instr_data, i_latch_data,
    output o_reg_addr, o_frame, o_eod, o_busy
  );
  modport master (
    output i_request_select, i_reg_data, i_pc, i_mem_data, i_instr_data, i_latch_data,
    input  o_reg_addr, o_frame, o_eod, o_busy
  );
endinterface

// File: rtl/mips_debug_frame_serializer.sv
// mips_debug_frame_serializer: sends the selected debug source as MSW-first frames followed by an EOD strobe.
// Define DBG_SNAPSHOT_EN to freeze the whole source at request time so multi-word bursts stay coherent.
module mips_debug_frame_serializer #(
  parameter int NB_FRAME = 32,
  parameter int NB_LATCH = 96,
  parameter int N_LATCH  = 8
) (
  input logic i_clock,
  input logic i_reset,
  mips_debug_frame_serializer_if.slave bus
);
  localparam int NW = NB_LATCH / NB_FRAME;
  typedef enum logic [1:0] {IDLE, SEND, EOD} state_e;
  state_e              state_q, state_d;
  logic [1:0]          n_q, n_d, idx_q, idx_d, req_n;
  logic [3:0]          sel_q, sel_d, req_sel;
  logic [4:0]          addr_q, addr_d;
  logic [NB_FRAME-1:0] frame_q, frame_d;
  logic                eod_q, eod_d;
  logic [5:0]          req, lat_off;
  logic                lat_hit, accept;
  logic [NB_LATCH-1:0] grp [N_LATCH];
  logic [NB_LATCH-1:0] src_new, cur;
  function automatic logic [NB_LATCH-1:0] pick(input logic [3:0] s, input logic [NB_FRAME-1:0] r, m, ins, p,
                                               input logic [NB_LATCH-1:0] g);
    logic [NB_FRAME-1:0] w;
    w = s[1:0] == 2'd0 ? r : s[1:0] == 2'd1 ? m : s[1:0] == 2'd2 ? ins : p;
    return s[3] ? g : NB_LATCH'(w) << (NB_LATCH - NB_FRAME);
  endfunction
  function automatic logic [NB_FRAME-1:0] word(input logic [NB_LATCH-1:0] v, input logic [1:0] k);
    return NB_FRAME'(v >> ((NW - 1 - int'(k)) * NB_FRAME));
  endfunction
  for (genvar g = 0; g < N_LATCH; g++) begin : g_grp
    assign grp[g] = bus.i_latch_data[g*NB_LATCH +: NB_LATCH];
  end
  assign req     = bus.i_request_select;
  assign lat_off = req - 6'd36;
  assign lat_hit = req[5] && lat_off < 6'(N_LATCH);
  assign accept  = state_q == IDLE && req != 6'h3F;
  // source code: 0 GPR, 1 data mem, 2 instr mem, 3 PC, {1,k} latch group k
  assign req_sel = !req[5] ? 4'd0 : lat_hit ? {1'b1, lat_off[2:0]} : {2'b00, req[1:0] + 2'd1};
  assign req_n   = !req[5] ? 2'd1 : lat_hit ? 2'(NW) : (req[4:2] == 3'b000 && req[1:0] != 2'b11) ? 2'd1 : 2'd0;
  assign src_new = pick(req_sel, bus.i_reg_data, bus.i_mem_data, bus.i_instr_data, bus.i_pc, grp[req_sel[2:0]]);
`ifdef DBG_SNAPSHOT_EN
  logic [NB_LATCH-1:0] snap_q, snap_d;
  assign snap_d = accept ? src_new : snap_q;
  always_ff @(posedge i_clock)
    if (!i_reset) snap_q <= '0;
    else snap_q <= snap_d;
  assign cur = snap_q;
`else
  assign cur = pick(sel_q, bus.i_reg_data, bus.i_mem_data, bus.i_instr_data, bus.i_pc, grp[sel_q[2:0]]);
`endif
  assign bus.o_reg_addr = state_q == IDLE ? req[4:0] : addr_q;
  assign bus.o_frame    = frame_q;
  assign bus.o_eod      = eod_q;
  assign bus.o_busy     = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    frame_d = '0;
    eod_d   = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = req_n != 2'd0 ? SEND : EOD;
        n_d     = req_n;
        idx_d   = 2'd0;
        sel_d   = req_sel;
        addr_d  = req[4:0];
        frame_d = req_n != 2'd0 ? word(src_new, 2'd0) : '0;
        eod_d   = req_n == 2'd0;
      end
      SEND: if (idx_q == n_q - 2'd1) begin
        state_d = EOD;
        eod_d   = 1'b1;
      end else begin
        idx_d   = idx_q + 2'd1;
        frame_d = word(cur, idx_q + 2'd1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clock)
    if (!i_reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      frame_q <= '0;
      eod_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      frame_q <= frame_d;
      eod_q   <= eod_d;
    end
endmodule

// File: doc/mips_debug_frame_serializer.md
# mips_debug_frame_serializer

MIPS-side responder of the MicroBlaze debug link. It watches the 6-bit request-select code driven by the debug interface and picks the addressed source: a GPR, the PC, the data-memory word, the instruction-memory word, or one of eight pipeline latch groups. It sends that source as a burst of 32-bit frames, most-significant word first, on the interface's MIPS frame input, then terminates the burst with a one-cycle end-of-data (EOD) strobe. It sits between the pipeline/debug taps and the debug interface's capture buffer.

## Interface
Parameters:
- NB_FRAME, 32, frame width; also width of GPR/PC/memory sources
- NB_LATCH, 96, width of each latch group; must be a multiple of NB_FRAME, at most 3*NB_FRAME (the capture buffer size)
- N_LATCH, 8, number of latch groups

Ports:
- i_clock  in  1  single clock, all logic on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_request_select  in  6  request code; 6'b111111 = no request
- o_reg_addr  out  5  GPR read address, combinational = i_request_select[4:0]
- i_reg_data  in  NB_FRAME  GPR read data (asynchronous read of o_reg_addr)
- i_pc  in  NB_FRAME  current PC
- i_mem_data  in  NB_FRAME  data-memory read word
- i_instr_data  in  NB_FRAME  instruction-memory read word
- i_latch_data  in  N_LATCH*NB_LATCH  latch group k at [k*NB_LATCH +: NB_LATCH]
- o_frame  out  NB_FRAME  outgoing frame (registered)
- o_eod  out  1  end-of-data strobe (registered)
- o_busy  out  1  high in SEND and EOD

## Operation
- Decode of i_request_select, evaluated in IDLE only:
  - 6'b0xxxxx → GPR i_request_select[4:0], 1 word
  - 6'b100000 → mem data, 1 word
  - 6'b100001 → instr mem, 1 word
  - 6'b100010 → PC, 1 word
  - 6'b100100..6'b101011 → latch group (code − 6'b100100), NB_LATCH/NB_FRAME words
  - 6'b111111 → no request
  - any other code → zero-word burst (EOD only)
- State machine:
  - IDLE: o_frame=0, o_eod=0. On any code other than 6'b111111: load word count n and source select, clear word index, go to SEND (n>0) or EOD (n=0).
  - SEND: drive word[index], MSW first (word 0 = bits [NB-1 -: NB_FRAME]). Index increments each cycle. After word n−1, go to EOD.
  - EOD: o_eod=1, o_frame=0 for one cycle, then IDLE.
- Requests arriving in SEND/EOD are ignored and never queued. The debug interface pulses select for one cycle only, so a dropped request is re-issued by firmware.
- Word index is 2 bits and never exceeds n−1; there is no wrap-around.
- Reset, including mid-burst: IDLE, o_frame=0, o_eod=0, o_busy=0. No EOD is emitted for the aborted burst.

## Timing
- Request sampled in cycle T.
- Word k on o_frame in cycle T+1+k, for k = 0..n−1.
- o_eod high in cycle T+n+1.
- Next request accepted from cycle T+n+2.
- Burst length:
  - 1-word source: T+1 data, T+2 EOD.
  - 96-bit latch: T+1..T+3 data, T+4 EOD.
  - Invalid code: T+1 EOD.
- o_reg_addr is combinational from i_request_select, so the register file returns i_reg_data within cycle T.
- o_busy rises in T+1 and falls after the EOD cycle.

## Configuration
- DBG_SNAPSHOT_EN defined:
  - In cycle T the whole selected source (up to NB_LATCH bits) is copied into a snapshot register.
  - All words come from the snapshot, so the burst is coherent even if the pipeline advances mid-burst.
- DBG_SNAPSHOT_EN undefined:
  - No snapshot register. Word k is read live from the selected source in cycle T+k, then registered.
  - The source select and GPR address are still latched in T, so the GPR address stays stable for the burst.
  - Multi-word latch bursts are coherent only while the pipeline is stalled.

## Test plan
- GPR: select 6'b000101, i_reg_data=32'hDEADBEEF → o_reg_addr=5 in T; o_frame=32'hDEADBEEF at T+1; o_eod=1 at T+2; then idle.
- Latch 3 (6'b100111), group 3 = 96'h111111112222222233333333 → frames 32'h11111111, 32'h22222222, 32'h33333333 at T+1..T+3; EOD at T+4.
- Invalid code 6'b100011 → o_eod=1 at T+1, o_frame=0, no data words.
- Select 6'b100010 (PC) at T+1 during a latch burst → ignored; burst completes unchanged; a PC request at T+5 is served with data at T+6.
- Snapshot coherence: latch 0 request, latch input changed at T+1 → with DBG_SNAPSHOT_EN all three words are the T values; without it, words 1–2 are the new values.
- i_reset=0 at T+2 of a latch burst → o_frame=0, o_eod=0, o_busy=0 next cycle; no EOD; after release, a new request is served normally.
